// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin front end sharing one mode-0 SPI bus between
// NREQ on-chip requesters. One byte per grant, full duplex, MSB first; the
// received byte is returned on rdata with a one-cycle done pulse to the owner.
module spi_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        edge_q;
  logic [7:0]        sr_q;
  logic              cap_q;
  logic [PW-1:0]     ptr_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic [7:0]        rdata_q;
  logic              busy_q;
  logic              cs_q;
  logic              sclk_q;
  logic              mosi_q;

  logic [7:0]        wbyte [NREQ];
  logic [PW-1:0]     win_d;
  logic [PW-1:0]     ptr_d;
  logic              tick;

  // First requester at or after the pointer, wrapping around. The loop runs
  // downward so the lowest offset from the pointer is the last one written.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] w;
    int j;
    w = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= NREQ) j = j - NREQ;
      if (r[PW'(j)]) w = PW'(j);
    end
    return w;
  endfunction

  // Split the flat write bus into per-requester bytes and pick the next winner.
  always_comb begin
    for (int i = 0; i < NREQ; i++) wbyte[i] = wdata[8*i +: 8];
    win_d = rr_pick(req, ptr_q);
    ptr_d = (win_d == PTR_LAST) ? '0 : win_d + 1'b1;
    tick  = (cnt_q == CNT_LAST);
  end

  // Transfer sequencer: arbitration, sclk pacing, shifting and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sr_q    <= '0;
      cap_q   <= 1'b0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= NREQ'(1) << win_d;
            sr_q    <= wbyte[win_d];
            mosi_q  <= wbyte[win_d][7];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            edge_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            cap_q   <= miso;
            edge_q  <= 4'd1;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            cnt_q  <= '0;
            edge_q <= edge_q + 1'b1;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              cap_q  <= miso;
            end else begin
              // Falling edge: shift in the bit captured on the rising edge.
              sclk_q <= 1'b0;
              sr_q   <= {sr_q[6:0], cap_q};
              mosi_q <= sr_q[6];
              if (edge_q == 4'd15) state_q <= HOLD;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            grant_q <= '0;
            rdata_q <= sr_q;
            done_q  <= grant_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign cs    = cs_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: a transaction-level timeline model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_spi_master_arbiter;

  localparam int NREQ = 4;
  localparam int CD   = 4;
  localparam int TLEN = 17 * CD;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] wdata = '0;
  logic [NREQ-1:0]   grant, done;
  logic [7:0]        rdata;
  logic              busy, cs, sclk, mosi, miso;

  logic       slave_mode = 1'b0;
  logic [7:0] slave_byte = 8'h5A;
  logic [7:0] s_reg = 8'h00;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  spi_master_arbiter #(.NREQ(NREQ), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .grant(grant), .done(done), .rdata(rdata), .busy(busy),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents its MSB when selected, shifts after each sclk fall.
  assign miso = slave_mode ? s_reg[7] : mosi;
  always @(negedge cs)   s_reg <= slave_byte;
  always @(negedge sclk) s_reg <= {s_reg[6:0], 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  logic       m_act = 1'b0;
  int         m_t = 0;
  int         m_own = 0;
  int         m_ptr = 0;
  logic [7:0] m_tx = 8'h00, m_rx = 8'h00, m_rdata = 8'h00;
  logic       m_found;
  int         m_j;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_ptr = 0; m_rdata = 8'h00;
    end else begin
      if (m_act) begin
        if (m_t == TLEN) m_act = 1'b0;
        else begin
          m_t++;
          if (m_t == TLEN) m_rdata = m_rx;
        end
      end
      if (!m_act && req != 0) begin
        m_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          m_j = (m_ptr + i) % NREQ;
          if (!m_found && req[m_j]) begin m_own = m_j; m_found = 1'b1; end
        end
        m_tx  = wdata[8*m_own +: 8];
        m_rx  = slave_mode ? slave_byte : m_tx;
        m_ptr = (m_own + 1) % NREQ;
        m_act = 1'b1;
        m_t   = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic xfer, e_sclk;
    if (!rst) begin
      xfer   = m_act && (m_t < TLEN);
      e_sclk = xfer && (m_t >= CD) && (m_t < 16*CD) && (((m_t / CD) % 2) == 1);
      check("cs",    cs,    !xfer);
      check("busy",  busy,  xfer);
      check("sclk",  sclk,  e_sclk);
      check("grant", grant, xfer ? (32'd1 << m_own) : 32'd0);
      check("done",  done,  (m_act && m_t == TLEN) ? (32'd1 << m_own) : 32'd0);
      check("rdata", rdata, m_rdata);
      if (e_sclk)                 check("mosi_bit", mosi, m_tx[7 - ((m_t / CD) - 1) / 2]);
      else if (xfer && m_t < CD)  check("mosi_setup", mosi, m_tx[7]);
    end
  end

  // ---------------- bus monitor ----------------
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  int         e0_cyc = 0, done_cyc = 0, done_cnt = 0, sclk_pulses = 0;
  logic [7:0] mosi_bits = 8'h00;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (prev_cs && !cs) e0_cyc = cyc;
    if (!prev_sclk && sclk) begin
      sclk_pulses++;
      mosi_bits = {mosi_bits[6:0], mosi};
    end
    if (done != 0) begin done_cyc = cyc; done_cnt++; end
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  task automatic wait_done(input string name, output logic [NREQ-1:0] d);
    d = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done != 0) begin d = done; return; end
    end
    n_vec++; n_fail++;
    $display("FAIL %s: no done pulse within 300 cycles, required one", name);
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    wdata[8*i +: 8] = b;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [NREQ-1:0] d;
    int base, dc;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Random traffic, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req   = NREQ'($urandom) | NREQ'(1);
      wdata = $urandom;
    end
    @(negedge clk);
    req = NREQ'($urandom); wdata = $urandom;
    #1 rst = 1'b1;
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    req = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback, requester 0 sends 0xBB.
    set_byte(0, 8'hBB);
    base = sclk_pulses;
    req = 4'b0001;
    wait_done("loop_done", d);
    req = '0;
    check("loop_owner", d, 4'b0001);
    check("loop_latency", done_cyc - e0_cyc, 68);
    check("loop_rdata", rdata, 8'hBB);
    check("loop_pulses", sclk_pulses - base, 8);
    check("loop_mosi", mosi_bits, 8'hBB);
    repeat (4) @(negedge clk);

    // Slave answers 0x5A while requester 1 sends 0xFF.
    slave_mode = 1'b1; slave_byte = 8'h5A;
    set_byte(1, 8'hFF);
    base = sclk_pulses;
    req = 4'b0010;
    wait_done("slave_done", d);
    req = '0;
    check("slave_owner", d, 4'b0010);
    check("slave_rdata", rdata, 8'h5A);
    check("slave_mosi", mosi_bits, 8'hFF);
    check("slave_pulses", sclk_pulses - base, 8);
    repeat (4) @(negedge clk);
    slave_mode = 1'b0;

    // All four held from reset: order 0,1,2,3 with a one-cycle cs gap.
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'h11 * (i + 1));
    req = 4'b1111;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      wait_done("rr_done", d);
      if (i == NREQ - 1) req = '0;
      check("rr_owner", d, 4'b0001 << i);
      check("rr_rdata", rdata, 8'h11 * (i + 1));
      if (i < NREQ - 1) begin
        @(negedge clk);
        check("rr_gap", e0_cyc - done_cyc, 1);
      end
    end
    repeat (3) @(negedge clk);
    req = 4'b0101;
    wait_done("pair_first", d);
    check("pair_first_owner", d, 4'b0001);
    wait_done("pair_second", d);
    req = '0;
    check("pair_second_owner", d, 4'b0100);
    repeat (4) @(negedge clk);

    // Reset after the 5th sclk rise, requester 3 held throughout.
    set_byte(3, 8'hC3);
    base = sclk_pulses;
    req = 4'b1000;
    for (int n = 0; n < 300 && sclk_pulses < base + 5; n++) @(negedge clk);
    check("abort_reached", sclk_pulses - base, 5);
    dc = done_cnt;
    #1 rst = 1'b1;
    #1;
    check("abort_cs", cs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_grant", grant, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    base = sclk_pulses;
    rst = 1'b0;
    wait_done("restart_done", d);
    req = '0;
    check("restart_owner", d, 4'b1000);
    check("restart_pulses", sclk_pulses - base, 8);
    check("restart_rdata", rdata, 8'hC3);
    check("restart_mosi", mosi_bits, 8'hC3);
    repeat (4) @(negedge clk);

    // Requester 2 drops its request two cycles after the transfer starts.
    set_byte(2, 8'h96);
    req = 4'b0100;
    for (int n = 0; n < 20 && cs; n++) @(negedge clk);
    check("drop_started", cs, 1'b0);
    repeat (2) @(negedge clk);
    req = '0;
    wait_done("drop_done", d);
    check("drop_owner", d, 4'b0100);
    check("drop_rdata", rdata, 8'h96);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("idle_grant", grant, 0);
      check("idle_cs", cs, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
